// File: rtl/store_bmp.sv
// store_bmp: reads a processed image (header followed by one gray byte per pixel)
// back from RAM and streams it out byte by byte with a valid/ready handshake.
// Header bytes pass through once; pixel bytes are emitted three times (B, G, R)
// when EXPAND=1, or once when EXPAND=0.
module store_bmp #(
   parameter int unsigned BYTE_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 20,
   parameter int unsigned HDR_SIZE   = 54,
   parameter int unsigned SRC_SIZE   = 54 + 65536,
   parameter int unsigned EXPAND     = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [BYTE_WIDTH-1:0] RAM_Q,
   output logic                  RAM_rd,
   output logic [ADDR_WIDTH-1:0] RAM_addr,
   output logic                  out_valid,
   output logic [BYTE_WIDTH-1:0] out_data,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  done
);

   localparam logic [ADDR_WIDTH-1:0] HdrSize = ADDR_WIDTH'(HDR_SIZE);
   localparam logic [ADDR_WIDTH-1:0] SrcLast = ADDR_WIDTH'(SRC_SIZE - 1);
   localparam logic                  NoExpand = (EXPAND == 0);

   typedef enum logic [2:0] {StIdle, StFetch, StLatch, StEmit, StDone} state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [BYTE_WIDTH-1:0]   hold_q, hold_d;
   logic [1:0]              rep_q, rep_d;
   logic                    byte_complete;

   // A byte is finished after one copy in the header or non-expanded mode,
   // otherwise after the third copy.
   assign byte_complete = (addr_q < HdrSize) || NoExpand || (rep_q == 2'd2);

   // State and datapath registers; reset abandons any transfer in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         addr_q  <= '0;
         hold_q  <= '0;
         rep_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         hold_q  <= hold_d;
         rep_q   <= rep_d;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      hold_d  = hold_q;
      rep_d   = rep_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StFetch;
               addr_d  = '0;
            end
         end
         StFetch: begin
            state_d = StLatch;
         end
         StLatch: begin
            // RAM_Q is valid now, one cycle after the read strobe.
            hold_d  = RAM_Q;
            rep_d   = 2'd0;
            state_d = StEmit;
         end
         StEmit: begin
            if (out_ready) begin
               if (byte_complete) begin
                  if (addr_q == SrcLast) begin
                     state_d = StDone;
                  end else begin
                     addr_d  = addr_q + ADDR_WIDTH'(1);
                     state_d = StFetch;
                  end
               end else begin
                  rep_d = rep_q + 2'd1;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Moore outputs decoded from the state; data comes straight from the hold register.
   always_comb begin
      RAM_rd    = (state_q == StFetch);
      out_valid = (state_q == StEmit);
      busy      = (state_q != StIdle);
      done      = (state_q == StDone);
      RAM_addr  = addr_q;
      out_data  = hold_q;
   end

endmodule

// File: tb/tb_store_bmp.sv
// Directed bench for store_bmp: expanded and non-expanded streams, backpressure,
// asynchronous reset mid-transfer, ignored start pulses and idle quiescence.
module tb_store_bmp;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_x = 1'b0, start_n = 1'b0;
   logic        out_ready = 1'b1;
   logic [7:0]  q_x = '0, q_n = '0;
   logic        rd_x, rd_n, valid_x, valid_n, busy_x, busy_n, done_x, done_n;
   logic [19:0] addr_x, addr_n;
   logic [7:0]  data_x, data_n;

   logic [7:0]  mem [0:5];

   int n_assert = 0;
   int n_fail   = 0;

   bit          sel_n = 1'b0;
   logic        o_rd, o_valid, o_busy, o_done;
   logic [19:0] o_addr;
   logic [7:0]  o_data;

   logic [7:0]  got[$];
   logic [19:0] rd_list[$];
   logic [7:0]  exp_x[$];
   logic [7:0]  exp_n[$];
   int          done_cnt, done_cyc, last_acc;
   logic        busy_after;

   always #5 clk = ~clk;

   store_bmp #(.BYTE_WIDTH(8), .ADDR_WIDTH(20), .HDR_SIZE(4), .SRC_SIZE(6), .EXPAND(1)) u_x (
      .clk(clk), .rst_n(rst_n), .start(start_x), .RAM_Q(q_x), .RAM_rd(rd_x),
      .RAM_addr(addr_x), .out_valid(valid_x), .out_data(data_x), .out_ready(out_ready),
      .busy(busy_x), .done(done_x)
   );

   store_bmp #(.BYTE_WIDTH(8), .ADDR_WIDTH(20), .HDR_SIZE(4), .SRC_SIZE(6), .EXPAND(0)) u_n (
      .clk(clk), .rst_n(rst_n), .start(start_n), .RAM_Q(q_n), .RAM_rd(rd_n),
      .RAM_addr(addr_n), .out_valid(valid_n), .out_data(data_n), .out_ready(out_ready),
      .busy(busy_n), .done(done_n)
   );

   // Synchronous-read RAM models: data appears the cycle after the read strobe.
   always @(posedge clk) begin
      if (rd_x) q_x <= mem[addr_x[2:0]];
      if (rd_n) q_n <= mem[addr_n[2:0]];
   end

   assign o_rd    = sel_n ? rd_n    : rd_x;
   assign o_valid = sel_n ? valid_n : valid_x;
   assign o_busy  = sel_n ? busy_n  : busy_x;
   assign o_done  = sel_n ? done_n  : done_x;
   assign o_addr  = sel_n ? addr_n  : addr_x;
   assign o_data  = sel_n ? data_n  : data_x;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic set_start(input bit v);
      if (sel_n) start_n = v;
      else       start_x = v;
   endtask

   // Runs one transfer on the selected instance, recording accepted bytes and reads.
   task automatic run_xfer(input bit use_n, input bit bp, input bit extra, input bit abort);
      int  stall;
      bit  seen_done;
      sel_n = use_n;
      got.delete();
      rd_list.delete();
      done_cnt   = 0;
      done_cyc   = -1;
      last_acc   = -1;
      stall      = 0;
      seen_done  = 1'b0;
      busy_after = 1'b1;
      out_ready  = 1'b1;
      @(posedge clk); #1;
      set_start(1'b1);
      for (int cyc = 0; cyc < 200; cyc++) begin
         @(posedge clk); #1;
         set_start(1'b0);
         if (extra && cyc == 3) set_start(1'b1);
         if (seen_done) begin
            busy_after = o_busy;
            break;
         end
         if (o_rd) rd_list.push_back(o_addr);
         if (o_done) begin
            done_cnt++;
            done_cyc  = cyc;
            seen_done = 1'b1;
            if (extra) set_start(1'b1);
         end
         if (abort && o_valid && o_data == 8'hFF) begin
            #2 rst_n = 1'b0;
            #1;
            chk("rst_valid", 32'(o_valid), 32'd0);
            chk("rst_busy", 32'(o_busy), 32'd0);
            chk("rst_addr", 32'(o_addr), 32'd0);
            chk("rst_done", 32'(o_done), 32'd0);
            #2 rst_n = 1'b1;
            break;
         end
         if (bp && o_valid && got.size() == 5 && stall < 5) begin
            out_ready = 1'b0;
            stall++;
            chk("bp_valid", 32'(o_valid), 32'd1);
            chk("bp_data", 32'(o_data), 32'h80);
         end else begin
            out_ready = 1'b1;
         end
         if (o_valid && out_ready) begin
            got.push_back(o_data);
            last_acc = cyc;
         end
      end
      set_start(1'b0);
      out_ready = 1'b1;
      if (!abort) chk("xfer_finished", 32'(seen_done), 32'd1);
      if (bp) chk("bp_stall_cycles", 32'(stall), 32'd5);
   endtask

   task automatic check_result(input string tag, input bit use_n);
      int n_exp;
      n_exp = use_n ? exp_n.size() : exp_x.size();
      chk({tag, "_len"}, 32'(got.size()), 32'(n_exp));
      for (int i = 0; i < n_exp && i < got.size(); i++)
         chk({tag, "_byte"}, 32'(got[i]), 32'(use_n ? exp_n[i] : exp_x[i]));
      chk({tag, "_rd_count"}, 32'(rd_list.size()), 32'd6);
      for (int i = 0; i < rd_list.size() && i < 6; i++)
         chk({tag, "_rd_addr"}, 32'(rd_list[i]), 32'(i));
      chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
      chk({tag, "_done_timing"}, 32'(done_cyc), 32'(last_acc + 1));
      chk({tag, "_busy_after"}, 32'(busy_after), 32'd0);
   endtask

   initial begin
      mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
      mem[3] = 8'h44; mem[4] = 8'h80; mem[5] = 8'hFF;
      exp_x = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h80, 8'h80, 8'h80, 8'hFF, 8'hFF, 8'hFF};
      exp_n = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h80, 8'hFF};

      // Reset state
      #12;
      chk("reset_rd", 32'(rd_x), 32'd0);
      chk("reset_valid", 32'(valid_x), 32'd0);
      chk("reset_busy", 32'(busy_x), 32'd0);
      chk("reset_done", 32'(done_x), 32'd0);
      chk("reset_addr", 32'(addr_x), 32'd0);
      chk("reset_data", 32'(data_x), 32'd0);
      chk("reset_n_valid", 32'(valid_n), 32'd0);
      rst_n = 1'b1;

      // Idle with start low for 20 cycles
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         chk("idle_quiet", 32'({rd_x, valid_x, busy_x, done_x}), 32'd0);
      end

      // Expanded stream
      run_xfer(1'b0, 1'b0, 1'b0, 1'b0);
      check_result("expand", 1'b0);

      // Non-expanded stream
      run_xfer(1'b1, 1'b0, 1'b0, 1'b0);
      check_result("plain", 1'b1);

      // Backpressure on the second copy of 80
      run_xfer(1'b0, 1'b1, 1'b0, 1'b0);
      check_result("backpressure", 1'b0);

      // Reset while FF is presented, then a clean rerun
      run_xfer(1'b0, 1'b0, 1'b0, 1'b1);
      run_xfer(1'b0, 1'b0, 1'b0, 1'b0);
      check_result("after_reset", 1'b0);

      // Start pulses while busy and in DONE are ignored
      run_xfer(1'b0, 1'b0, 1'b1, 1'b0);
      check_result("extra_start", 1'b0);
      repeat (3) begin
         @(posedge clk); #1;
         chk("extra_start_idle", 32'(busy_x), 32'd0);
      end
      run_xfer(1'b0, 1'b0, 1'b0, 1'b0);
      check_result("second_run", 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
